// File: rtl/mem_pkg.sv
// Shared definitions for the handshaked memory responder: FSM state encoding and bus widths.
package mem_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x WORD_W storage with a synchronous write port and a registered read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rd_clr_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto RAM macros; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= rd_clr_i ? '0 : mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Handshaked memory responder: FSM, wait counter, request capture and ack generation.
// Define MEM_ERR_EN to add the out-of-range err output and suppress wrapped accesses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  output logic              busy
`ifdef MEM_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic [WORD_W-1:0] wdata_q;
  logic              oor_q;

  logic              capture;
  logic              commit;
  logic [IDX_W-1:0]  txn_idx;
  logic              txn_we;
  logic [WORD_W-1:0] txn_wdata;
  logic              txn_oor;
  logic              req_oor;

  assign capture = (state_q == S_IDLE) && req;

`ifdef MEM_ERR_EN
  assign req_oor = {1'b0, addr} >= (ADDR_W + 1)'(DEPTH);
`else
  assign req_oor = 1'b0;
`endif

  generate
    if (IDX_W < ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // With zero wait states the commit edge is also the capture edge, so use the live inputs then.
  assign txn_idx   = (state_q == S_IDLE) ? addr[IDX_W-1:0] : idx_q;
  assign txn_we    = (state_q == S_IDLE) ? we              : we_q;
  assign txn_wdata = (state_q == S_IDLE) ? wdata           : wdata_q;
  assign txn_oor   = (state_q == S_IDLE) ? req_oor         : oor_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= addr[IDX_W-1:0];
        we_q    <= we;
        wdata_q <= wdata;
        oor_q   <= req_oor;
      end
    end
  end

  // NOTE: every comb output gets a default first so no latch is inferred on unlisted paths.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        cnt_d   = CNT_W'(WAIT_STATES);
        state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack  = (state_q == S_RESP);
    busy = (state_q != S_IDLE);
`ifdef MEM_ERR_EN
    err  = (state_q == S_RESP) && oor_q;
`endif
  end

  // RAM write and read-data update both land on the edge entering RESP; reset aborts it.
  assign commit = !reset && (state_q != S_RESP) && (state_d == S_RESP);

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .we_i     (commit && txn_we && !txn_oor),
    .re_i     (commit && !txn_we),
    .rd_clr_i (txn_oor),
    .idx_i    (txn_idx),
    .wdata_i  (txn_wdata),
    .rdata_o  (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH=256, WAIT_STATES=2); honours MEM_ERR_EN.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic        err;

  int tests  = 0;
  int failed = 0;

  mem_responder #(
    .DEPTH       (256),
    .WAIT_STATES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .busy  (busy)
`ifdef MEM_ERR_EN
    ,
    .err   (err)
`endif
  );

`ifndef MEM_ERR_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request pulse, then wait (bounded) for ack; leaves the DUT back in IDLE.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic e);
    we = w; addr = a; wdata = d; req = 1'b1;
    tick();
    req = 1'b0;
    lat = 0; rd = 16'hxxxx; e = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (ack) begin
        lat = c; rd = rdata; e = err;
        break;
      end
      tick();
    end
    tick();
  endtask

  int          lat;
  logic [15:0] rd;
  logic        e;
  int          ack_cyc [2];
  logic [15:0] ack_dat [2];
  int          n_ack;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Preload known contents (RAM is never cleared by reset).
    access(1'b1, 16'd5,  16'h0000, lat, rd, e);
    access(1'b1, 16'd7,  16'h7777, lat, rd, e);
    access(1'b1, 16'd9,  16'h5555, lat, rd, e);
    access(1'b1, 16'd1,  16'h1111, lat, rd, e);
    access(1'b1, 16'd2,  16'h2222, lat, rd, e);
    access(1'b1, 16'd0,  16'h0A0A, lat, rd, e);
    access(1'b0, 16'd9,  16'h0000, lat, rd, e);
    check("preload_read9", {16'h0, rd}, 32'h5555);

    // Reset values
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_ack",   {31'h0, ack},  32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_rdata", {16'h0, rdata}, 32'h0);
`ifdef MEM_ERR_EN
    check("rst_err",   {31'h0, err},  32'h0);
`endif

    // 1: read addr 5, cycle-accurate ack/busy
    we = 1'b0; addr = 16'd5; req = 1'b1;
    tick();
    req = 1'b0;
    check("t1_c1_ack",  {31'h0, ack},  32'h0);
    check("t1_c1_busy", {31'h0, busy}, 32'h1);
    tick();
    check("t1_c2_ack",  {31'h0, ack},  32'h0);
    check("t1_c2_busy", {31'h0, busy}, 32'h1);
    tick();
    check("t1_c3_ack",   {31'h0, ack},   32'h1);
    check("t1_c3_busy",  {31'h0, busy},  32'h1);
    check("t1_c3_rdata", {16'h0, rdata}, 32'h0000);
    tick();
    check("t1_c4_ack",  {31'h0, ack},  32'h0);
    check("t1_c4_busy", {31'h0, busy}, 32'h0);

    // 2: write then read 0x0010
    access(1'b1, 16'h0010, 16'hA5C3, lat, rd, e);
    check("t2_wr_lat",   lat, 3);
    check("t2_wr_rdata", {16'h0, rd}, 32'h0000);
    access(1'b0, 16'h0010, 16'h0000, lat, rd, e);
    check("t2_rd_lat",   lat, 3);
    check("t2_rd_rdata", {16'h0, rd}, 32'hA5C3);

    // 3: inputs changed during WAIT are ignored
    we = 1'b1; addr = 16'd3; wdata = 16'h1234; req = 1'b1;
    tick();
    req = 1'b0; we = 1'b0; addr = 16'd7; wdata = 16'hDEAD;
    tick();
    check("t3_c2_ack", {31'h0, ack}, 32'h0);
    tick();
    check("t3_c3_ack", {31'h0, ack}, 32'h1);
    tick();
    access(1'b0, 16'd3, 16'h0000, lat, rd, e);
    check("t3_addr3", {16'h0, rd}, 32'h1234);
    access(1'b0, 16'd7, 16'h0000, lat, rd, e);
    check("t3_addr7", {16'h0, rd}, 32'h7777);

    // 4: reset during WAIT abandons the write
    we = 1'b1; addr = 16'd9; wdata = 16'hFFFF; req = 1'b1;
    tick();
    req = 1'b0;
    check("t4_wait_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_rst_busy",  {31'h0, busy},  32'h0);
    check("t4_rst_ack",   {31'h0, ack},   32'h0);
    check("t4_rst_rdata", {16'h0, rdata}, 32'h0);
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      if (ack) n_ack++;
      tick();
    end
    check("t4_no_ack", n_ack, 0);
    access(1'b0, 16'd9, 16'h0000, lat, rd, e);
    check("t4_addr9", {16'h0, rd}, 32'h5555);

    // Reset in RESP: write already committed, ack drops next cycle
    we = 1'b1; addr = 16'h0011; wdata = 16'h4242; req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick();
    check("t4b_resp_ack", {31'h0, ack}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4b_after_ack", {31'h0, ack}, 32'h0);
    access(1'b0, 16'h0011, 16'h0000, lat, rd, e);
    check("t4b_committed", {16'h0, rd}, 32'h4242);

    // 5: req held high for back-to-back reads of 1 then 2
    we = 1'b0; addr = 16'd1; req = 1'b1;
    tick();
    addr = 16'd2;
    n_ack = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0;
    ack_dat[0] = 'x; ack_dat[1] = 'x;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) req = 1'b0;
      if (ack && n_ack < 2) begin
        ack_cyc[n_ack] = c;
        ack_dat[n_ack] = rdata;
        n_ack++;
      end
      tick();
    end
    check("t5_n_ack",   n_ack, 2);
    check("t5_ack0_cy", ack_cyc[0], 3);
    check("t5_ack1_cy", ack_cyc[1], 7);
    check("t5_ack0_d",  {16'h0, ack_dat[0]}, 32'h1111);
    check("t5_ack1_d",  {16'h0, ack_dat[1]}, 32'h2222);

    // 6: address 0x0100 is out of range / wraps to 0
    access(1'b1, 16'h0100, 16'hBEEF, lat, rd, e);
    check("t6_wr_lat", lat, 3);
`ifdef MEM_ERR_EN
    check("t6_wr_err", {31'h0, e}, 32'h1);
    check("t6_err_cleared", {31'h0, err}, 32'h0);
    access(1'b0, 16'h0000, 16'h0000, lat, rd, e);
    check("t6_addr0", {16'h0, rd}, 32'h0A0A);
    check("t6_rd0_err", {31'h0, e}, 32'h0);
    access(1'b0, 16'h0100, 16'h0000, lat, rd, e);
    check("t6_oor_rdata", {16'h0, rd}, 32'h0000);
    check("t6_oor_err", {31'h0, e}, 32'h1);
`else
    access(1'b0, 16'h0000, 16'h0000, lat, rd, e);
    check("t6_addr0_wrap", {16'h0, rd}, 32'hBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
